fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller sitting directly downstream of the next-PC stage. It owns the architectural PC register and feeds it back as the next-PC stage's current PC. It consumes that stage's next-PC result and drives a variable-latency instruction-memory request/ack port. Fetched instructions go to decode through a valid/ready IF/ID register backed by a one-entry skid buffer, and a taken-branch flush kills in-flight work.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, value driven on o_id_instr while invalid/reset
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_next_pc  in  32  next PC from next-PC stage (pc+4 or branch target)
- i_b_taken  in  1  taken branch/flush from execute; same signal drives next-PC mux select
- o_pc  out  32  current PC register; feeds next-PC stage i_pc
- o_imem_req  out  1  instruction memory request
- o_imem_addr  out  32  request address; stable while o_imem_req=1 and no ack
- i_imem_ack  in  1  response valid; meaningful only while o_imem_req=1
- i_imem_rdata  in  32  instruction word, valid with i_imem_ack
- o_id_valid  out  1  IF/ID register holds a live instruction
- o_id_instr  out  32  instruction to decode
- o_id_pc  out  32  PC of o_id_instr
- i_id_ready  in  1  decode accepts; transfer when o_id_valid & i_id_ready

## Operation
- States: FETCH (request pc), HOLD (skid full, no request), KILL (flushed request still outstanding).
- FETCH: o_imem_req=1, o_imem_addr=o_pc. Ack may arrive the same cycle as req or any later cycle.
- Ack in FETCH, no flush, output free (!o_id_valid | i_id_ready): output <= {rdata, o_pc}, o_id_valid<=1, o_pc<=i_next_pc, stay FETCH.
- Ack in FETCH, no flush, output blocked: skid <= {rdata, o_pc}, o_pc<=i_next_pc, go HOLD.
- HOLD: o_imem_req=0. When i_id_ready, skid moves into output, go FETCH.
- Output with o_id_valid & i_id_ready and no new data: o_id_valid<=0, o_id_instr<=NOP_INSTR.
- Flush (i_b_taken=1), any state: o_pc<=i_next_pc; output and skid invalidated; o_id_instr<=NOP_INSTR.
  - Flush in FETCH without ack: kill_addr<=o_pc, go KILL.
  - Flush with ack in the same cycle: data discarded, go FETCH.
  - Flush in HOLD: go FETCH.
  - Flush in KILL: stay KILL, kill_addr unchanged.
- KILL: o_imem_req=1, o_imem_addr=kill_addr. The ack is discarded and the block goes to FETCH.
- Flush has priority over the decode handshake.
- Reset mid-operation: all state dropped. The memory shares i_reset and abandons any outstanding request.
- PC arithmetic is 32-bit and wraps modulo 2^32. No alignment checking.

## Timing
- Reset values: o_pc=RESET_PC, o_id_valid=0, o_id_instr=NOP_INSTR, o_id_pc=0, state FETCH.
- o_imem_req is forced to 0 while i_reset=1.
- Ack at edge N produces o_id_valid/o_id_instr/o_id_pc and the updated o_pc after edge N.
- Zero-wait memory with i_id_ready=1 sustains one instruction per cycle.
- After a flush at edge N, the first request to the target is issued in cycle N+1, or one cycle after the killed ack.
- Skid drain: i_id_ready rising in HOLD sends the skid entry to output on that edge. The request resumes the next cycle.

## Configuration
- FETCH_TRACE_EN defined:
  - on every instruction entering the output register: $display "fetch pc=%0h instr=%0h";
  - on every flush: $display "fetch flush target=%0h".
- FETCH_TRACE_EN undefined: no simulation output.
- Synthesizable logic is identical in both cases.

## Test plan
- Reset, RESET_PC=0, zero-wait memory returning addr^32'hA5A5A5A5, i_id_ready=1 -> o_id_pc 0,4,8,C on consecutive cycles, o_id_valid continuous, instr matching.
- i_id_ready=0 for 3 cycles while 0x8 is in output -> 0x8 held, 0xC captured in skid, o_imem_req=0 in HOLD; after ready, 0xC then 0x10 with no loss or duplicate.
- Flush to 0x100 in FETCH with 3-cycle memory -> o_imem_addr holds old 0x10 until ack, data discarded, next request 0x100, o_id_pc never 0x10.
- Flush to 0x200 coincident with ack and i_id_ready=0 -> o_id_valid=0 next cycle, skid empty, next request 0x200.
- i_reset pulsed in HOLD -> next cycle o_pc=RESET_PC, o_id_valid=0, o_id_instr=32'h13, o_imem_req=1 at RESET_PC after release.
- Flush while already in KILL -> single killed ack consumed, then request to the latest target only.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues variable-latency imem requests and
// feeds decode through an IF/ID register with a one-entry skid. Define FETCH_TRACE_EN for a fetch/flush trace.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_next_pc,
  input  logic        i_b_taken,
  output logic [31:0] o_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_id_valid,
  output logic [31:0] o_id_instr,
  output logic [31:0] o_id_pc,
  input  logic        i_id_ready
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_KILL  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        accept;

  // Next-state and datapath selection; flush wins over every handshake.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_addr_d  = kill_addr_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    accept       = id_valid_q & i_id_ready;

    if (i_b_taken) begin
      pc_d       = i_next_pc;
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
      case (state_q)
        ST_FETCH: begin
          if (i_imem_ack) begin
            state_d = ST_FETCH;
          end else begin
            kill_addr_d = pc_q;
            state_d     = ST_KILL;
          end
        end
        ST_HOLD: state_d = ST_FETCH;
        ST_KILL: begin
          // A second flush keeps waiting for the original killed ack.
          if (i_imem_ack) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_KILL;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (i_imem_ack) begin
            pc_d = i_next_pc;
            if (!id_valid_q || i_id_ready) begin
              id_valid_d = 1'b1;
              id_instr_d = i_imem_rdata;
              id_pc_d    = pc_q;
            end else begin
              skid_instr_d = i_imem_rdata;
              skid_pc_d    = pc_q;
              state_d      = ST_HOLD;
            end
          end else if (accept) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_HOLD: begin
          // Output is always occupied here, so a ready cycle is a straight swap.
          if (i_id_ready) begin
            id_valid_d = 1'b1;
            id_instr_d = skid_instr_q;
            id_pc_d    = skid_pc_q;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_KILL: begin
          if (i_imem_ack) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_KILL;
          end
          if (accept) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
          end else begin
            id_valid_d = id_valid_q;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      kill_addr_q  <= 32'h0000_0000;
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP_INSTR;
      id_pc_q      <= 32'h0000_0000;
      skid_instr_q <= 32'h0000_0000;
      skid_pc_q    <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_addr_q  <= kill_addr_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign o_imem_req  = !i_reset && (state_q != ST_HOLD);
  assign o_imem_addr = (state_q == ST_KILL) ? kill_addr_q : pc_q;
  assign o_pc        = pc_q;
  assign o_id_valid  = id_valid_q;
  assign o_id_instr  = id_instr_q;
  assign o_id_pc     = id_pc_q;

`ifdef FETCH_TRACE_EN
  // Simulation trace of output-register loads and flushes.
  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_b_taken &&
        ((state_q == ST_FETCH && i_imem_ack && (!id_valid_q || i_id_ready)) ||
         (state_q == ST_HOLD && i_id_ready))) begin
      $display("fetch pc=%0h instr=%0h", id_pc_d, id_instr_d);
    end
    if (!i_reset && i_b_taken) begin
      $display("fetch flush target=%0h", i_next_pc);
    end
  end
`else
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed per-cycle vector table for the corner cases, then a
// randomized run checked against an instruction-stream reference model.
module tb_fetch_ctrl;

  logic        i_clk;
  logic        i_reset;
  logic [31:0] i_next_pc;
  logic        i_b_taken;
  logic [31:0] o_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        o_id_valid;
  logic [31:0] o_id_instr;
  logic [31:0] o_id_pc;
  logic        i_id_ready;

  fetch_ctrl dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_next_pc   (i_next_pc),
    .i_b_taken   (i_b_taken),
    .o_pc        (o_pc),
    .o_imem_req  (o_imem_req),
    .o_imem_addr (o_imem_addr),
    .i_imem_ack  (i_imem_ack),
    .i_imem_rdata(i_imem_rdata),
    .o_id_valid  (o_id_valid),
    .o_id_instr  (o_id_instr),
    .o_id_pc     (o_id_pc),
    .i_id_ready  (i_id_ready)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  localparam logic [31:0] NOP = 32'h0000_0013;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  int wait_cnt = 0;
  logic s_req, s_ack;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        taken;
    logic [31:0] target;
    int          lat;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_idpc;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[23];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs (including the next-PC stage and memory) after the negedge.
  task automatic drive(input logic rst, input logic ready, input logic taken,
                       input logic [31:0] target, input int l);
    i_reset    = rst;
    i_id_ready = ready;
    i_b_taken  = taken;
    i_next_pc  = taken ? target : o_pc + 32'd4;
    lat        = l;
    #1;
    i_imem_ack   = o_imem_req && (wait_cnt >= lat);
    i_imem_rdata = i_imem_ack ? mem_word(o_imem_addr) : 32'hDEAD_BEEF;
    s_req = o_imem_req;
    s_ack = i_imem_ack;
  endtask

  task automatic clock_edge();
    @(posedge i_clk);
    if (i_reset) wait_cnt = 0;
    else if (s_req) wait_cnt = s_ack ? 0 : wait_cnt + 1;
    @(negedge i_clk);
  endtask

  task automatic set_vec(input int idx, input logic rst, input logic ready, input logic taken,
                         input logic [31:0] target, input int l, input logic ereq,
                         input logic [31:0] eaddr, input logic evalid,
                         input logic [31:0] eidpc, input logic [31:0] epc);
    vecs[idx].rst = rst;     vecs[idx].ready = ready;   vecs[idx].taken = taken;
    vecs[idx].target = target; vecs[idx].lat = l;
    vecs[idx].exp_req = ereq;  vecs[idx].exp_addr = eaddr; vecs[idx].exp_valid = evalid;
    vecs[idx].exp_idpc = eidpc; vecs[idx].exp_pc = epc;
  endtask

  logic [31:0] exp_stream_pc;
  logic        pend;
  logic [31:0] pend_addr;
  logic        rst_r, rdy_r, tk_r;
  logic [31:0] tgt_r;
  int          idle;
  int          delivered;

  initial begin
    i_reset = 1'b1; i_id_ready = 1'b1; i_b_taken = 1'b0; i_next_pc = 32'h0;
    i_imem_ack = 1'b0; i_imem_rdata = 32'h0;
    s_req = 1'b0; s_ack = 1'b0;

    //      idx rst rdy tk  target        lat  req addr          vld idpc          pc
    set_vec( 0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0);
    set_vec( 1, 0, 1, 0, 32'h0,        0, 1, 32'h4,        1, 32'h0,        32'h4);
    set_vec( 2, 0, 1, 0, 32'h0,        0, 1, 32'h8,        1, 32'h4,        32'h8);
    set_vec( 3, 0, 0, 0, 32'h0,        0, 1, 32'hC,        1, 32'h8,        32'hC);
    set_vec( 4, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h8,        32'h10);
    set_vec( 5, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h8,        32'h10);
    set_vec( 6, 0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h8,        32'h10);
    set_vec( 7, 0, 1, 0, 32'h0,        3, 1, 32'h10,       1, 32'hC,        32'h10);
    set_vec( 8, 0, 1, 1, 32'h100,      3, 1, 32'h10,       0, 32'h0,        32'h10);
    set_vec( 9, 0, 1, 0, 32'h0,        3, 1, 32'h10,       0, 32'h0,        32'h100);
    set_vec(10, 0, 1, 0, 32'h0,        3, 1, 32'h10,       0, 32'h0,        32'h100);
    set_vec(11, 0, 1, 0, 32'h0,        0, 1, 32'h100,      0, 32'h0,        32'h100);
    set_vec(12, 0, 0, 1, 32'h200,      0, 1, 32'h104,      1, 32'h100,      32'h104);
    set_vec(13, 0, 0, 0, 32'h0,        0, 1, 32'h200,      0, 32'h0,        32'h200);
    set_vec(14, 0, 0, 0, 32'h0,        0, 1, 32'h204,      1, 32'h200,      32'h204);
    set_vec(15, 1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h200,      32'h208);
    set_vec(16, 0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0);
    set_vec(17, 0, 1, 1, 32'h300,      2, 1, 32'h4,        1, 32'h0,        32'h4);
    set_vec(18, 0, 1, 1, 32'h400,      2, 1, 32'h4,        0, 32'h0,        32'h300);
    set_vec(19, 0, 1, 0, 32'h0,        2, 1, 32'h4,        0, 32'h0,        32'h400);
    set_vec(20, 0, 1, 0, 32'h0,        0, 1, 32'h400,      0, 32'h0,        32'h400);
    set_vec(21, 0, 1, 0, 32'h0,        0, 1, 32'h404,      1, 32'h400,      32'h404);
    set_vec(22, 0, 1, 0, 32'h0,        0, 1, 32'h408,      1, 32'h404,      32'h408);

    @(negedge i_clk);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 0); clock_edge();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 0); clock_edge();

    // Directed table: outputs checked at the start of each cycle, then that row's inputs applied.
    for (int i = 0; i < 23; i++) begin
      chk($sformatf("v%0d_req", i), {31'h0, o_imem_req}, {31'h0, vecs[i].exp_req});
      if (vecs[i].exp_req) chk($sformatf("v%0d_addr", i), o_imem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_valid", i), {31'h0, o_id_valid}, {31'h0, vecs[i].exp_valid});
      chk($sformatf("v%0d_instr", i), o_id_instr,
          vecs[i].exp_valid ? mem_word(vecs[i].exp_idpc) : NOP);
      if (vecs[i].exp_valid) chk($sformatf("v%0d_idpc", i), o_id_pc, vecs[i].exp_idpc);
      chk($sformatf("v%0d_pc", i), o_pc, vecs[i].exp_pc);
      drive(vecs[i].rst, vecs[i].ready, vecs[i].taken, vecs[i].target, vecs[i].lat);
      clock_edge();
    end

    // Randomized run: decode must see target, target+4, ... after every flush/reset.
    drive(1'b1, 1'b1, 1'b0, 32'h0, 0); clock_edge();
    exp_stream_pc = 32'h0;
    pend = 1'b0; pend_addr = 32'h0;
    idle = 0; delivered = 0;
    for (int c = 0; c < 4000; c++) begin
      rst_r = ($urandom_range(0, 599) == 0);
      rdy_r = ($urandom_range(0, 9) < 7);
      tk_r  = !rst_r && ($urandom_range(0, 19) == 0);
      tgt_r = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      drive(rst_r, rdy_r, tk_r, tgt_r, $urandom_range(0, 3));
      if (rst_r) begin
        chk("rnd_req_in_reset", {31'h0, o_imem_req}, 32'h0);
      end
      if (pend && !rst_r) begin
        chk("rnd_req_held", {31'h0, o_imem_req}, 32'h1);
        chk("rnd_addr_stable", o_imem_addr, pend_addr);
      end
      if (!o_id_valid) chk("rnd_idle_nop", o_id_instr, NOP);
      if (o_id_valid && rdy_r && !tk_r && !rst_r) begin
        chk("rnd_stream_pc", o_id_pc, exp_stream_pc);
        chk("rnd_stream_instr", o_id_instr, mem_word(exp_stream_pc));
        delivered++;
      end
      pend      = o_imem_req && !i_imem_ack && !rst_r;
      pend_addr = o_imem_addr;
      if (rst_r) begin
        exp_stream_pc = 32'h0;
        idle = 0;
      end else if (tk_r) begin
        exp_stream_pc = tgt_r;
        idle = 0;
      end else if (o_id_valid && rdy_r) begin
        exp_stream_pc = exp_stream_pc + 32'd4;
        idle = 0;
      end else begin
        idle++;
      end
      checks++;
      if (idle > 60) begin
        errors++;
        $display("FAIL rnd_progress: %0d idle cycles, required at most 60", idle);
        idle = 0;
      end
      clock_edge();
    end
    chk("rnd_delivered_enough", (delivered > 1000) ? 32'h1 : 32'h0, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
